// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the data memory.
// Port 0 is the CPU load/store unit, port 1 the calculator front-end.
// Each transaction takes four cycles: IDLE -> ACCESS -> RESP -> DONE.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | arbitrate, latch the winning request, drive memory address/data
// ACCESS | memory write-enable active for this single cycle (if writing)
// RESP   | memory registered read data valid, captured at closing edge
// DONE   | done/err pulse for the winning port, no arbitration
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter bit CHECK_ADDR = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              done0_o,
    output logic              done1_o,
    output logic              err0_o,
    output logic              err1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              mem_writeEnable_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_dataInput_o,
    input  logic [DATA_W-1:0] mem_dataOutput_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // The memory only decodes these byte addresses; note the stride changes
    // from 4 to 2 after 0x10 and back to 4 from 0x12 on.
    localparam int N_MAPPED = 17;
    localparam logic [31:0] MAPPED_ADDRS [N_MAPPED] = '{
        32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h12, 32'h16, 32'h1A,
        32'h1E, 32'h22, 32'h26, 32'h2A, 32'h2E, 32'h32, 32'h36, 32'h3A,
        32'h3E
    };

    function automatic logic addr_is_mapped(input logic [ADDR_W-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_MAPPED; i++) begin
            if (a == ADDR_W'(MAPPED_ADDRS[i])) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic                mapped_q, mapped_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                err0_q, err0_d;
    logic                err1_q, err1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    // Arbitration candidates, only consumed in IDLE.
    logic                any_req;
    logic                both_req;
    logic                win;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_mapped;
    logic [DATA_W-1:0]   resp_data;

    // Pick the winner: a lone requester wins outright; on a tie the port that
    // did not win the previous tie is served, so neither port can starve.
    always_comb begin
        any_req    = req0_i | req1_i;
        both_req   = req0_i & req1_i;
        win        = both_req ? ~last_grant_q : req1_i;
        sel_we     = win ? we1_i : we0_i;
        sel_addr   = win ? addr1_i : addr0_i;
        sel_wdata  = win ? wdata1_i : wdata0_i;
        sel_mapped = CHECK_ADDR ? addr_is_mapped(sel_addr) : 1'b1;
        resp_data  = (mapped_q & ~we_q) ? mem_dataOutput_i : '0;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed four-cycle walk once a request is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: busy flag and next values of all registered outputs.
    always_comb begin
        busy_o       = (state_q != S_IDLE);
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        mapped_d     = mapped_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        done0_d      = done0_q;
        done1_d      = done1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d      = win;
                    we_d       = sel_we;
                    mapped_d   = sel_mapped;
                    mem_addr_d = sel_addr;
                    mem_din_d  = sel_wdata;
                    // Unmapped writes never touch the memory.
                    mem_we_d   = ~(sel_we & sel_mapped);
                    // Only a tie moves the round-robin pointer.
                    if (both_req) begin
                        last_grant_d = win;
                    end
                end
            end
            S_ACCESS: begin
                // Address stays put so the memory registers the read here.
                mem_we_d = 1'b1;
            end
            S_RESP: begin
                if (gnt_q) begin
                    rdata1_d = resp_data;
                    done1_d  = 1'b1;
                    err1_d   = ~mapped_q;
                end else begin
                    rdata0_d = resp_data;
                    done0_d  = 1'b1;
                    err0_d   = ~mapped_q;
                end
            end
            S_DONE: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                err0_d  = 1'b0;
                err1_d  = 1'b0;
            end
            default: begin
                mem_we_d = 1'b1;
            end
        endcase
    end

    // Datapath registers; a reset mid-transaction drops it without a done.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            mapped_q     <= 1'b0;
            mem_we_q     <= 1'b1;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            mapped_q     <= mapped_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign done0_o           = done0_q;
    assign done1_o           = done1_q;
    assign err0_o            = err0_q;
    assign err1_o            = err1_q;
    assign rdata0_o          = rdata0_q;
    assign rdata1_o          = rdata1_q;
    assign mem_writeEnable_o = mem_we_q;
    assign mem_address_o     = mem_addr_q;
    assign mem_dataInput_o   = mem_din_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (address checking on and off) share
// the same stimulus, each with its own behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;

    logic        done0, done1, err0, err1, mwe, busy;
    logic [31:0] rdata0, rdata1, maddr, mdin, mdout;
    logic        done0_nc, done1_nc, err0_nc, err1_nc, mwe_nc, busy_nc;
    logic [31:0] rdata0_nc, rdata1_nc, maddr_nc, mdin_nc, mdout_nc;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .CHECK_ADDR(1'b1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .done0_o(done0), .done1_o(done1), .err0_o(err0), .err1_o(err1),
        .rdata0_o(rdata0), .rdata1_o(rdata1),
        .mem_writeEnable_o(mwe), .mem_address_o(maddr), .mem_dataInput_o(mdin),
        .mem_dataOutput_i(mdout), .busy_o(busy)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .CHECK_ADDR(1'b0)) u_dut_nc (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .done0_o(done0_nc), .done1_o(done1_nc), .err0_o(err0_nc), .err1_o(err1_nc),
        .rdata0_o(rdata0_nc), .rdata1_o(rdata1_nc),
        .mem_writeEnable_o(mwe_nc), .mem_address_o(maddr_nc), .mem_dataInput_o(mdin_nc),
        .mem_dataOutput_i(mdout_nc), .busy_o(busy_nc)
    );

    localparam logic [31:0] MAP [17] = '{
        32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h12, 32'h16, 32'h1A,
        32'h1E, 32'h22, 32'h26, 32'h2A, 32'h2E, 32'h32, 32'h36, 32'h3A,
        32'h3E
    };

    function automatic int mem_slot(input logic [31:0] a);
        for (int i = 0; i < 17; i++) if (a == MAP[i]) return i;
        return -1;
    endfunction

    // Environment memories: word store at the 17 addresses, active-low write
    // on negedge, registered read on posedge, 0 for any other address.
    logic [31:0] mem_a [17] = '{default: 32'h0};
    logic [31:0] mem_b [17] = '{default: 32'h0};

    always @(negedge clk) begin
        int s;
        s = mem_slot(maddr);
        if (!mwe && s >= 0) mem_a[s[4:0]] <= mdin;
    end
    always @(posedge clk) begin
        int s;
        s = mem_slot(maddr);
        mdout <= (s >= 0) ? mem_a[s[4:0]] : 32'h0;
    end
    always @(negedge clk) begin
        int s;
        s = mem_slot(maddr_nc);
        if (!mwe_nc && s >= 0) mem_b[s[4:0]] <= mdin_nc;
    end
    always @(posedge clk) begin
        int s;
        s = mem_slot(maddr_nc);
        mdout_nc <= (s >= 0) ? mem_b[s[4:0]] : 32'h0;
    end

    // Reference model: contents by address, plus the tie-break pointer.
    logic [31:0] ref_mem [logic [31:0]];
    logic        rr_last;

    function automatic logic ref_mapped(input logic [31:0] a);
        return mem_slot(a) >= 0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (ref_mapped(a) && ref_mem.exists(a)) return ref_mem[a];
        return 32'h0;
    endfunction

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one or two requests from an idle DUT and check every served
    // transaction at fixed offsets from its sampling edge. late1 raises req1
    // only during the first ACCESS cycle.
    task automatic run(input logic r0, input logic r1, input logic late1,
                       input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        logic        pend0, pend1, p0, p1, win, sw, mp, exp_we, exp_we_nc, exp_err;
        logic [31:0] sa, sd, exp_rd;
        we0 = w0; addr0 = a0; wdata0 = d0;
        we1 = w1; addr1 = a1; wdata1 = d1;
        req0 = r0; req1 = r1 & ~late1;
        pend0 = r0; pend1 = r1;
        for (int k = 0; k < 2; k++) begin
            if (!(pend0 || pend1)) break;
            if (k == 1) @(posedge clk);
            @(posedge clk);
            p0 = pend0 && req0;
            p1 = pend1 && req1;
            if (p0 && p1) begin
                win     = ~rr_last;
                rr_last = win;
            end else begin
                win = p1;
            end
            sw = win ? w1 : w0;
            sa = win ? a1 : a0;
            sd = win ? d1 : d0;
            mp = ref_mapped(sa);
            exp_we    = ~(sw & mp);
            exp_we_nc = ~sw;
            exp_err   = ~mp;
            exp_rd    = sw ? 32'h0 : ref_read(sa);
            @(negedge clk);
            if (late1 && k == 0) req1 = r1;
            chk("busy_access", busy, 1);
            chk("we_access", mwe, exp_we);
            chk("addr_access", maddr, sa);
            chk("nc_we_access", mwe_nc, exp_we_nc);
            if (sw) chk("din_access", mdin, sd);
            @(negedge clk);
            chk("we_resp", mwe, 1);
            chk("done0_resp", done0, 0);
            chk("done1_resp", done1, 0);
            @(negedge clk);
            chk("we_done", mwe, 1);
            if (win) begin
                chk("done1", done1, 1);
                chk("done0_loser", done0, 0);
                chk("err1", err1, exp_err);
                chk("rdata1", rdata1, exp_rd);
                chk("nc_done1", done1_nc, 1);
                chk("nc_err1", err1_nc, 0);
                chk("nc_rdata1", rdata1_nc, exp_rd);
                req1 = 1'b0; pend1 = 1'b0;
            end else begin
                chk("done0", done0, 1);
                chk("done1_loser", done1, 0);
                chk("err0", err0, exp_err);
                chk("rdata0", rdata0, exp_rd);
                chk("nc_done0", done0_nc, 1);
                chk("nc_err0", err0_nc, 0);
                chk("nc_rdata0", rdata0_nc, exp_rd);
                req0 = 1'b0; pend0 = 1'b0;
            end
            if (sw && mp) ref_mem[sa] = sd;
        end
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("we_idle", mwe, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        rr_last = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we", mwe, 1);
        chk("rst_addr", maddr, 0);
        chk("rst_din", mdin, 0);
        chk("rst_done0", done0, 0);
        chk("rst_err1", err1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Port 0 write then read of 0x0C.
        run(1, 0, 0, 1, 32'h0C, 32'hDEADBEEF, 0, 0, 0);
        run(1, 0, 0, 0, 32'h0C, 0, 0, 0, 0);
        // Preload 0x04/0x08 from port 1 (lone requests leave the pointer).
        run(0, 1, 0, 0, 0, 0, 1, 32'h04, 32'h11110004);
        run(0, 1, 0, 0, 0, 0, 1, 32'h08, 32'h22220008);
        // Tie: port 0 first, then tie again: port 1 first.
        run(1, 1, 0, 0, 32'h04, 0, 0, 32'h08, 0);
        run(1, 1, 0, 0, 32'h04, 0, 0, 32'h08, 0);
        // Unmapped write from port 1, then confirm 0x04 is untouched.
        run(0, 1, 0, 0, 0, 0, 1, 32'h05, 32'h12345678);
        run(1, 0, 0, 0, 32'h04, 0, 0, 0, 0);
        run(0, 1, 0, 0, 0, 0, 0, 32'h05, 0);

        // Reset at the edge that would enter RESP on a read of 0x3E.
        req0 = 1; we0 = 0; addr0 = 32'h3E;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rr_last = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done0", done0, 0);
        chk("abort_err0", err0, 0);
        chk("abort_we", mwe, 1);
        @(negedge clk);
        chk("abort_done0_later", done0, 0);
        run(1, 0, 0, 0, 32'h3E, 0, 0, 0, 0);

        // Port 0 writes 0xAA to 0x3E; port 1 raises a read during ACCESS.
        run(1, 1, 1, 1, 32'h3E, 32'h000000AA, 0, 32'h3E, 0);

        // Randomized traffic against the model.
        for (int it = 0; it < 30; it++) begin
            logic        r0, r1, w0, w1;
            logic [31:0] a0, a1, d0, d1;
            int          sel;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 21);
            a0 = (sel < 17) ? MAP[sel] : 32'($urandom_range(0, 70));
            sel = $urandom_range(0, 21);
            a1 = (sel < 17) ? MAP[sel] : 32'($urandom_range(0, 70));
            d0 = $urandom;
            d1 = $urandom;
            run(r0, r1, 0, w0, a0, d0, w1, a1, d1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
